// File: rtl/pipe_pkg.sv
// Shared definitions for elastic pipeline stages and the checkers bound to them.
package pipe_pkg;

    localparam int OCC_W = 2;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b10
    } pipe_state_e;

    // Live-entry count for a state; an illegal encoding reports nothing held.
    function automatic logic [OCC_W-1:0] occ_of(input pipe_state_e s);
        logic [OCC_W-1:0] occ;
        occ = 2'd0;
        case (s)
            EMPTY:   occ = 2'd0;
            ONE:     occ = 2'd1;
            FULL:    occ = 2'd2;
            default: occ = 2'd0;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/pipe_skid_stage_if.sv
// Handshake bundle around one elastic stage: upstream push, downstream pop, flush.
// valid/ready: a word moves on a rising edge where valid & ready are both high;
// valid must hold with stable data until taken, ready may change freely.
interface pipe_skid_stage_if #(
    parameter int WIDTH = 32
);
    import pipe_pkg::*;

    logic               flush;
    logic               in_valid;
    logic [WIDTH-1:0]   in_data;
    logic               in_ready;
    logic               out_valid;
    logic [WIDTH-1:0]   out_data;
    logic               out_ready;
    logic [OCC_W-1:0]   occupancy;
    pipe_state_e        state;

    // Environment side: produces upstream words and consumes the head.
    modport master (
        output flush, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, occupancy, state
    );

    // Stage side.
    modport slave (
        input  flush, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, occupancy, state
    );

endinterface

// File: rtl/pipe_reg_en.sv
// Payload register with load enable and synchronous clear; clear wins over load.
module pipe_reg_en #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_skid_stage.sv
// Elastic stage register: head register drives out_data, skid register absorbs the
// one word already in flight when downstream stalls. in_ready/out_valid are flops.
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter bit FLUSH_ZERO = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    pipe_skid_stage_if.slave bus
);

    pipe_state_e       state;
    pipe_state_e       state_nxt;
    logic              in_ready_q;
    logic              out_valid_q;
    logic [OCC_W-1:0]  occ_q;

    logic              can_acc;
    logic              holds_head;
    logic              acc;
    logic              pop;
    logic              main_en;
    logic              skid_en;
    logic              clr;
    logic [WIDTH-1:0]  main_d;
    logic [WIDTH-1:0]  main_q;
    logic [WIDTH-1:0]  skid_q;

    // Decode from state rather than the output flops so an illegal encoding
    // neither accepts nor pops while it falls back to EMPTY.
    always_comb begin
        can_acc    = (state == EMPTY) || (state == ONE);
        holds_head = (state == ONE) || (state == FULL);
        acc        = bus.in_valid & can_acc & ~bus.flush;
        pop        = holds_head & bus.out_ready;
    end

    always_comb begin
        main_en = 1'b0;
        skid_en = 1'b0;
        main_d  = bus.in_data;
        clr     = bus.flush & FLUSH_ZERO;
        case (state)
            EMPTY: main_en = acc;
            ONE: begin
                main_en = pop & acc;
                skid_en = ~pop & acc;
            end
            FULL: begin
                main_en = pop & ~bus.flush;
                main_d  = skid_q;
            end
            default: begin
                main_en = 1'b0;
                skid_en = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY: state_nxt = acc ? ONE : EMPTY;
            ONE: begin
                if (pop && !acc) begin
                    state_nxt = EMPTY;
                end else if (!pop && acc) begin
                    state_nxt = FULL;
                end else begin
                    state_nxt = ONE;
                end
            end
            FULL:    state_nxt = pop ? ONE : FULL;
            default: state_nxt = EMPTY;
        endcase
        if (bus.flush) begin
            state_nxt = EMPTY;
        end
    end

    // Output flops are loaded from the next state so they never lag the FSM.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            occ_q       <= '0;
        end else begin
            state       <= state_nxt;
            in_ready_q  <= (state_nxt != FULL);
            out_valid_q <= (state_nxt != EMPTY);
            occ_q       <= occ_of(state_nxt);
        end
    end

    pipe_reg_en #(.WIDTH(WIDTH)) u_main (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .en  (main_en),
        .d   (main_d),
        .q   (main_q)
    );

    pipe_reg_en #(.WIDTH(WIDTH)) u_skid (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .en  (skid_en),
        .d   (bus.in_data),
        .q   (skid_q)
    );

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = main_q;
    assign bus.occupancy = occ_q;
    assign bus.state     = state;

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: vector table on a 32-bit flush-zeroing stage, and a
// queue scoreboard driving a 117-bit stage that keeps payload on flush.
module tb_pipe_skid_stage;

    localparam int W1 = 117;

    typedef struct {
        logic        fl;
        logic        iv;
        logic [31:0] d;
        logic        ordy;
        logic        ov;
        logic [31:0] od;
        logic        ir;
        logic [1:0]  occ;
    } vec_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    vec_t          vecs[$];
    logic [W1-1:0] exp_q[$];

    pipe_skid_stage_if #(.WIDTH(32)) bus0 ();
    pipe_skid_stage_if #(.WIDTH(W1)) bus1 ();

    pipe_skid_stage #(.WIDTH(32), .FLUSH_ZERO(1'b1)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    pipe_skid_stage #(.WIDTH(W1), .FLUSH_ZERO(1'b0)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle0();
        bus0.flush = 1'b0; bus0.in_valid = 1'b0; bus0.in_data = '0; bus0.out_ready = 1'b0;
    endtask

    task automatic idle1();
        bus1.flush = 1'b0; bus1.in_valid = 1'b0; bus1.in_data = '0; bus1.out_ready = 1'b0;
    endtask

    function automatic vec_t mk(input logic fl, input logic iv, input logic [31:0] d,
                                input logic ordy, input logic ov, input logic [31:0] od,
                                input logic ir, input logic [1:0] occ);
        vec_t v;
        v.fl = fl; v.iv = iv; v.d = d; v.ordy = ordy;
        v.ov = ov; v.od = od; v.ir = ir; v.occ = occ;
        return v;
    endfunction

    // One cycle on dut1 against the queue model: the queue is the stage contents.
    task automatic cyc1(input logic fl, input logic iv, input logic [W1-1:0] d, input logic ordy);
        logic pop;
        logic acc;
        bus1.flush = fl; bus1.in_valid = iv; bus1.in_data = d; bus1.out_ready = ordy;
        pop = (exp_q.size() != 0) && ordy;
        acc = iv && (exp_q.size() < 2) && !fl;
        if (pop) void'(exp_q.pop_front());
        if (fl) exp_q.delete();
        else if (acc) exp_q.push_back(d);
        tick();
        chk("occupancy", 128'(bus1.occupancy), 128'(exp_q.size()));
        chk("out_valid", 128'(bus1.out_valid), 128'(exp_q.size() != 0));
        chk("in_ready", 128'(bus1.in_ready), 128'(exp_q.size() != 2));
        if (exp_q.size() != 0) chk("out_data order", 128'(bus1.out_data), 128'(exp_q[0]));
    endtask

    initial begin
        logic [127:0] r;
        n_checks = 0;
        n_errors = 0;
        rst = 1'b0;
        idle0();
        idle1();

        // Reset held two cycles with a live input on both stages.
        bus0.in_valid = 1'b1; bus0.in_data = 32'hDEAD_BEEF;
        bus1.in_valid = 1'b1; bus1.in_data = W1'(32'hDEAD_BEEF);
        tick();
        tick();
        chk("rst0 out_valid", 128'(bus0.out_valid), 128'(0));
        chk("rst0 out_data", 128'(bus0.out_data), 128'(0));
        chk("rst0 in_ready", 128'(bus0.in_ready), 128'(1));
        chk("rst0 occupancy", 128'(bus0.occupancy), 128'(0));
        chk("rst1 out_valid", 128'(bus1.out_valid), 128'(0));
        chk("rst1 out_data", 128'(bus1.out_data), 128'(0));
        chk("rst1 in_ready", 128'(bus1.in_ready), 128'(1));
        chk("rst1 occupancy", 128'(bus1.occupancy), 128'(0));
        idle1();
        rst = 1'b1;

        // Streaming 1..8 with out_ready high, then drain.
        for (int i = 1; i <= 8; i++)
            vecs.push_back(mk(1'b0, 1'b1, 32'(i), 1'b1, 1'b1, 32'(i), 1'b1, 2'd1));
        vecs.push_back(mk(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h8, 1'b1, 2'd0));
        // Back-pressure: A held, B skidded, C refused, then drain.
        vecs.push_back(mk(1'b0, 1'b1, 32'hA, 1'b0, 1'b1, 32'hA, 1'b1, 2'd1));
        vecs.push_back(mk(1'b0, 1'b1, 32'hB, 1'b0, 1'b1, 32'hA, 1'b0, 2'd2));
        vecs.push_back(mk(1'b0, 1'b1, 32'hC, 1'b0, 1'b1, 32'hA, 1'b0, 2'd2));
        vecs.push_back(mk(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'hB, 1'b1, 2'd1));
        vecs.push_back(mk(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'hB, 1'b1, 2'd0));
        // Flush while FULL with a same-cycle input and pop.
        vecs.push_back(mk(1'b0, 1'b1, 32'h11, 1'b0, 1'b1, 32'h11, 1'b1, 2'd1));
        vecs.push_back(mk(1'b0, 1'b1, 32'h22, 1'b0, 1'b1, 32'h11, 1'b0, 2'd2));
        vecs.push_back(mk(1'b1, 1'b1, 32'h33, 1'b1, 1'b0, 32'h0, 1'b1, 2'd0));
        vecs.push_back(mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 2'd0));
        vecs.push_back(mk(1'b0, 1'b1, 32'h44, 1'b1, 1'b1, 32'h44, 1'b1, 2'd1));
        vecs.push_back(mk(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h44, 1'b1, 2'd0));
        // Flush from ONE.
        vecs.push_back(mk(1'b0, 1'b1, 32'h5A, 1'b0, 1'b1, 32'h5A, 1'b1, 2'd1));
        vecs.push_back(mk(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 2'd0));

        for (int i = 0; i < vecs.size(); i++) begin
            bus0.flush = vecs[i].fl; bus0.in_valid = vecs[i].iv;
            bus0.in_data = vecs[i].d; bus0.out_ready = vecs[i].ordy;
            tick();
            chk($sformatf("vec%0d out_valid", i), 128'(bus0.out_valid), 128'(vecs[i].ov));
            chk($sformatf("vec%0d out_data", i), 128'(bus0.out_data), 128'(vecs[i].od));
            chk($sformatf("vec%0d in_ready", i), 128'(bus0.in_ready), 128'(vecs[i].ir));
            chk($sformatf("vec%0d occupancy", i), 128'(bus0.occupancy), 128'(vecs[i].occ));
        end
        idle0();

        // Flush without zeroing, with a same-cycle input and pop: head payload stays.
        cyc1(1'b0, 1'b1, W1'(32'h77), 1'b0);
        cyc1(1'b1, 1'b1, W1'(32'h99), 1'b1);
        chk("fz0 retained head", 128'(bus1.out_data), 128'(32'h77));
        cyc1(1'b0, 1'b1, W1'(32'h55), 1'b0);
        chk("fz0 accept after flush", 128'(bus1.out_data), 128'(32'h55));
        cyc1(1'b0, 1'b0, '0, 1'b1);

        // Random traffic; ready bias shifts every 1000 cycles.
        for (int i = 0; i < 10000; i++) begin
            int rdy_pct;
            rdy_pct = ((i / 1000) % 2 == 0) ? 80 : 35;
            r = {$urandom, $urandom, $urandom, $urandom};
            cyc1(($urandom_range(0, 63) == 0),
                 ($urandom_range(0, 3) != 0),
                 r[W1-1:0],
                 ($urandom_range(0, 99) < rdy_pct));
        end

        // Reset in the middle of traffic clears the payload even without flush zeroing.
        cyc1(1'b0, 1'b1, W1'(32'hAAAA), 1'b0);
        cyc1(1'b0, 1'b1, W1'(32'hBBBB), 1'b0);
        idle1();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        exp_q.delete();
        chk("midrst out_valid", 128'(bus1.out_valid), 128'(0));
        chk("midrst out_data", 128'(bus1.out_data), 128'(0));
        chk("midrst in_ready", 128'(bus1.in_ready), 128'(1));
        chk("midrst occupancy", 128'(bus1.occupancy), 128'(0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
